axi_write_arbiter: RTL and testbench
====================================

# axi_write_arbiter

Two-master write-channel arbiter for the AXI bridge, the write-side companion to the bridge's read arbitration. It grants one master (M0 = CPU instruction/data port 0, M1 = port 1) ownership of the shared AW/W/B path, holds that grant for one complete write transaction (address, data burst through WLAST, response), then releases it with round-robin priority. It drives the write mux selects and forwards the granted master's handshakes to the slave-side decoder.

## Interface
- ADDR_WIDTH, 32, AW address width
- ID_WIDTH, 4, master ID width; M0 = 0, M1 = 1, none = all ones
- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-low
- AWVALID_M0, AWVALID_M1  in  1  master write-address valid
- AWADDR_M0, AWADDR_M1  in  ADDR_WIDTH  master write address
- WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1  in  1  master write-data valid/last
- BREADY_M0, BREADY_M1  in  1  master response ready
- AWREADY, WREADY, BVALID  in  1  from slave-side decoder
- AWREADY_M0, AWREADY_M1, WREADY_M0, WREADY_M1, BVALID_M0, BVALID_M1  out  1  routed to masters
- AWVALID, WVALID, WLAST, BREADY  out  1  granted master's signals to decoder
- AWADDR  out  ADDR_WIDTH  registered address of granted master
- MasterID  out  ID_WIDTH  granted master ID
- WriteAddressSel, WriteDataSel, WriteRespSel  out  2  mux selects: 2'b01 M0, 2'b10 M1, 2'b00 none

## Operation
- States: IDLE, ADDR, DATA, RESP. Priority pointer `prio` (M0 or M1).
- IDLE: no grant; all outputs to decoder and masters 0, selects 2'b00, MasterID all ones. If any AWVALID_Mx: grant = sole requester, or `prio` when both request; register grant, AWADDR_Mx, MasterID; go ADDR.
- ADDR: AWVALID = granted AWVALID_Mx; AWREADY_Mx(granted) = AWREADY, other = 0. On AWVALID && AWREADY -> DATA. WREADY_Mx both 0, WVALID 0.
- DATA: WVALID/WLAST = granted master's; WREADY_Mx(granted) = WREADY. On WVALID && WREADY && WLAST -> RESP. Non-last beats stay in DATA.
- RESP: BVALID_Mx(granted) = BVALID; BREADY = granted BREADY_Mx. On BVALID && BREADY -> IDLE; `prio` toggles to the master not just served.
- Non-granted master sees all ready/valid outputs 0 in every state.
- Grant, AWADDR, MasterID, selects constant from ADDR entry through RESP exit; a second master's AWVALID never alters them.
- Selects: WriteAddressSel valid in ADDR; WriteDataSel in DATA; WriteRespSel in RESP; each 2'b00 otherwise.

## Timing
- Reset (async, any state): state IDLE, `prio` = M0, AWADDR 0, MasterID all ones, selects 2'b00, all 1-bit outputs 0. Mid-transaction reset abandons the transaction; no response forwarded.
- Request to decoder AWVALID: 1 cycle (IDLE sample, ADDR drives).
- All ready/valid forwarding inside a state is combinational (same cycle); state transitions on the handshake cycle's clock edge.
- Minimum transaction: single-beat write with immediate readies = 4 cycles (IDLE, ADDR, DATA, RESP); next grant sampled in the following IDLE cycle.
- W data presented by the master before AW handshake is stalled (WREADY_Mx = 0) until DATA.
- Both masters requesting continuously: strict alternation M0, M1, M0, ... starting with M0 after reset.
- Back-to-back requests from one master while other idle: served every transaction regardless of `prio`.

## Test plan
- Reset: hold reset=0 with random inputs -> all outputs 0, selects 2'b00, MasterID 4'hF; release -> state IDLE.
- Single M0 write, AWADDR_M0=32'h0001_0004, 1 beat, slave readies high -> AWADDR=32'h0001_0004, MasterID=0, AWVALID on cycle 2, BVALID_M0 pulse on cycle 4, BVALID_M1 stays 0.
- Simultaneous AWVALID_M0/M1 for 4 transactions -> grant order M0, M1, M0, M1; WriteAddressSel 01,10,01,10.
- M1 4-beat burst with WREADY toggling every cycle, M0 requests mid-burst -> M0 held off (AWREADY_M0=0) until M1's B handshake; exactly 4 WREADY_M1 handshakes, DATA->RESP only on WLAST beat.
- BVALID high, BREADY_M0 low for 3 cycles -> stays RESP, grant unchanged; exits IDLE cycle after BREADY_M0=1.
- Assert reset=0 during DATA -> outputs cleared asynchronously same cycle; after release, M1 request granted first only if `prio` reset to M0 and M0 idle.

Source files
------------

// File: rtl/axi_write_arbiter_if.sv
// Write-channel bundle between the two CPU masters, the write arbiter and the slave-side decoder.
// slave is the arbiter's view; master is the environment's (masters plus decoder) view.
interface axi_write_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
);
    // Master-side request/data/response
    logic                  AWVALID_M0;
    logic                  AWVALID_M1;
    logic [ADDR_WIDTH-1:0] AWADDR_M0;
    logic [ADDR_WIDTH-1:0] AWADDR_M1;
    logic                  WVALID_M0;
    logic                  WVALID_M1;
    logic                  WLAST_M0;
    logic                  WLAST_M1;
    logic                  BREADY_M0;
    logic                  BREADY_M1;
    logic                  AWREADY_M0;
    logic                  AWREADY_M1;
    logic                  WREADY_M0;
    logic                  WREADY_M1;
    logic                  BVALID_M0;
    logic                  BVALID_M1;

    // Decoder side
    logic                  AWREADY;
    logic                  WREADY;
    logic                  BVALID;
    logic                  AWVALID;
    logic                  WVALID;
    logic                  WLAST;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [ID_WIDTH-1:0]   MasterID;
    logic [1:0]            WriteAddressSel;
    logic [1:0]            WriteDataSel;
    logic [1:0]            WriteRespSel;

    modport slave (
        input  AWVALID_M0, AWVALID_M1, AWADDR_M0, AWADDR_M1,
        input  WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1,
        input  BREADY_M0, BREADY_M1,
        input  AWREADY, WREADY, BVALID,
        output AWREADY_M0, AWREADY_M1, WREADY_M0, WREADY_M1, BVALID_M0, BVALID_M1,
        output AWVALID, WVALID, WLAST, BREADY, AWADDR, MasterID,
        output WriteAddressSel, WriteDataSel, WriteRespSel
    );

    modport master (
        output AWVALID_M0, AWVALID_M1, AWADDR_M0, AWADDR_M1,
        output WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1,
        output BREADY_M0, BREADY_M1,
        output AWREADY, WREADY, BVALID,
        input  AWREADY_M0, AWREADY_M1, WREADY_M0, WREADY_M1, BVALID_M0, BVALID_M1,
        input  AWVALID, WVALID, WLAST, BREADY, AWADDR, MasterID,
        input  WriteAddressSel, WriteDataSel, WriteRespSel
    );
endinterface

// File: rtl/axi_write_arbiter.sv
// Two-master AXI write arbiter: owns AW/W/B for one full transaction per grant and
// rotates priority round-robin after each write response.
module axi_write_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                clock,
    input  logic                reset,
    axi_write_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e                state_q, state_d;
    logic                  prio_q, prio_d;     // 0: M0 wins a tie, 1: M1 wins a tie
    logic                  grant_q, grant_d;   // 0: M0 owns the path, 1: M1
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [1:0]            aw_sel_q, aw_sel_d;
    logic [1:0]            w_sel_q, w_sel_d;
    logic [1:0]            b_sel_q, b_sel_d;

    logic in_addr, in_data, in_resp;
    logic g_awvalid, g_wvalid, g_wlast, g_bready;
    logic aw_hs, w_last_hs, b_hs;
    logic [1:0] grant_onehot;

    assign in_addr = (state_q == StAddr);
    assign in_data = (state_q == StData);
    assign in_resp = (state_q == StResp);

    assign g_awvalid = grant_q ? bus.AWVALID_M1 : bus.AWVALID_M0;
    assign g_wvalid  = grant_q ? bus.WVALID_M1  : bus.WVALID_M0;
    assign g_wlast   = grant_q ? bus.WLAST_M1   : bus.WLAST_M0;
    assign g_bready  = grant_q ? bus.BREADY_M1  : bus.BREADY_M0;

    assign grant_onehot = grant_q ? 2'b10 : 2'b01;

    assign aw_hs     = in_addr & g_awvalid & bus.AWREADY;
    assign w_last_hs = in_data & g_wvalid & bus.WREADY & g_wlast;
    assign b_hs      = in_resp & bus.BVALID & g_bready;

    // Handshake forwarding is combinational within a state; the loser sees zeros throughout.
    assign bus.AWVALID    = in_addr & g_awvalid;
    assign bus.AWREADY_M0 = in_addr & ~grant_q & bus.AWREADY;
    assign bus.AWREADY_M1 = in_addr &  grant_q & bus.AWREADY;
    assign bus.WVALID     = in_data & g_wvalid;
    assign bus.WLAST      = in_data & g_wlast;
    assign bus.WREADY_M0  = in_data & ~grant_q & bus.WREADY;
    assign bus.WREADY_M1  = in_data &  grant_q & bus.WREADY;
    assign bus.BVALID_M0  = in_resp & ~grant_q & bus.BVALID;
    assign bus.BVALID_M1  = in_resp &  grant_q & bus.BVALID;
    assign bus.BREADY     = in_resp & g_bready;

    assign bus.AWADDR          = awaddr_q;
    assign bus.MasterID        = id_q;
    assign bus.WriteAddressSel = aw_sel_q;
    assign bus.WriteDataSel    = w_sel_q;
    assign bus.WriteRespSel    = b_sel_q;

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        grant_d  = grant_q;
        awaddr_d = awaddr_q;
        id_d     = id_q;
        aw_sel_d = aw_sel_q;
        w_sel_d  = w_sel_q;
        b_sel_d  = b_sel_q;
        unique case (state_q)
            StIdle: begin
                if (bus.AWVALID_M0 || bus.AWVALID_M1) begin
                    // Tie goes to prio; a sole requester wins regardless of prio.
                    grant_d  = (bus.AWVALID_M0 && bus.AWVALID_M1) ? prio_q : bus.AWVALID_M1;
                    awaddr_d = grant_d ? bus.AWADDR_M1 : bus.AWADDR_M0;
                    id_d     = grant_d ? ID_WIDTH'(1) : '0;
                    aw_sel_d = grant_d ? 2'b10 : 2'b01;
                    state_d  = StAddr;
                end
            end
            StAddr: begin
                if (aw_hs) begin
                    aw_sel_d = 2'b00;
                    w_sel_d  = grant_onehot;
                    state_d  = StData;
                end
            end
            StData: begin
                if (w_last_hs) begin
                    w_sel_d = 2'b00;
                    b_sel_d = grant_onehot;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (b_hs) begin
                    b_sel_d  = 2'b00;
                    prio_d   = ~grant_q;
                    id_d     = '1;
                    awaddr_d = '0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            prio_q   <= 1'b0;
            grant_q  <= 1'b0;
            awaddr_q <= '0;
            id_q     <= '1;
            aw_sel_q <= 2'b00;
            w_sel_q  <= 2'b00;
            b_sel_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            grant_q  <= grant_d;
            awaddr_q <= awaddr_d;
            id_q     <= id_d;
            aw_sel_q <= aw_sel_d;
            w_sel_q  <= w_sel_d;
            b_sel_q  <= b_sel_d;
        end
    end
endmodule

// File: tb/tb_axi_write_arbiter.sv
// Bench for axi_write_arbiter: a table of write transactions with expected grants, a
// scoreboard of expected grant/address/select, and hand sequences for reset corners.
module tb_axi_write_arbiter;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    axi_write_arbiter_if #(.ADDR_WIDTH(32), .ID_WIDTH(4)) bus ();

    axi_write_arbiter #(.ADDR_WIDTH(32), .ID_WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          req0;
        bit          req1;
        logic [31:0] addr0;
        logic [31:0] addr1;
        int          beats;
        bit          toggle;     // WREADY alternates 0/1 during the burst
        bit          midreq;     // other master raises AWVALID during DATA
        int          bwait;      // cycles BVALID is held with BREADY low
        bit          exp_grant;
    } vec_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [1:0]  sel;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[9];
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [9:0] out_flags();
        return {bus.AWREADY_M0, bus.AWREADY_M1, bus.WREADY_M0, bus.WREADY_M1,
                bus.BVALID_M0, bus.BVALID_M1, bus.AWVALID, bus.WVALID, bus.WLAST, bus.BREADY};
    endfunction

    function automatic logic awready_of(input bit g);
        return g ? bus.AWREADY_M1 : bus.AWREADY_M0;
    endfunction

    function automatic logic wready_of(input bit g);
        return g ? bus.WREADY_M1 : bus.WREADY_M0;
    endfunction

    function automatic logic bvalid_of(input bit g);
        return g ? bus.BVALID_M1 : bus.BVALID_M0;
    endfunction

    task automatic drive_m(input bit g, input logic awv, input logic wv, input logic wl,
                           input logic br);
        if (g) begin
            bus.AWVALID_M1 = awv; bus.WVALID_M1 = wv; bus.WLAST_M1 = wl; bus.BREADY_M1 = br;
        end else begin
            bus.AWVALID_M0 = awv; bus.WVALID_M0 = wv; bus.WLAST_M0 = wl; bus.BREADY_M0 = br;
        end
    endtask

    task automatic zero_inputs();
        bus.AWVALID_M0 = 1'b0; bus.AWVALID_M1 = 1'b0;
        bus.AWADDR_M0 = '0;    bus.AWADDR_M1 = '0;
        bus.WVALID_M0 = 1'b0;  bus.WVALID_M1 = 1'b0;
        bus.WLAST_M0 = 1'b0;   bus.WLAST_M1 = 1'b0;
        bus.BREADY_M0 = 1'b0;  bus.BREADY_M1 = 1'b0;
        bus.AWREADY = 1'b0;    bus.WREADY = 1'b0;    bus.BVALID = 1'b0;
    endtask

    task automatic random_inputs();
        bus.AWVALID_M0 = 1'($urandom); bus.AWVALID_M1 = 1'($urandom);
        bus.AWADDR_M0 = $urandom;      bus.AWADDR_M1 = $urandom;
        bus.WVALID_M0 = 1'($urandom);  bus.WVALID_M1 = 1'($urandom);
        bus.WLAST_M0 = 1'($urandom);   bus.WLAST_M1 = 1'($urandom);
        bus.BREADY_M0 = 1'($urandom);  bus.BREADY_M1 = 1'($urandom);
        bus.AWREADY = 1'($urandom);    bus.WREADY = 1'($urandom);
        bus.BVALID = 1'($urandom);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_flags"}, out_flags(), 10'h000);
        check({tag, "_sels"}, {bus.WriteAddressSel, bus.WriteDataSel, bus.WriteRespSel}, 6'h00);
        check({tag, "_id"}, bus.MasterID, 4'hF);
        check({tag, "_awaddr"}, bus.AWADDR, 32'h0);
    endtask

    // Runs one write transaction starting in IDLE; ends one cycle into the following IDLE.
    task automatic do_txn(input vec_t v);
        exp_t e;
        exp_t got;
        bit   g;
        int   hs;
        int   cyc;
        g = v.exp_grant;
        bus.AWADDR_M0 = v.addr0;  bus.AWADDR_M1 = v.addr1;
        bus.AWVALID_M0 = v.req0;  bus.AWVALID_M1 = v.req1;
        bus.AWREADY = 1'b1; bus.WREADY = 1'b0; bus.BVALID = 1'b0;
        e.id   = g ? 4'd1 : 4'd0;
        e.addr = g ? v.addr1 : v.addr0;
        e.sel  = g ? 2'b10 : 2'b01;
        sb_q.push_back(e);
        #1;
        check("idle_awvalid", bus.AWVALID, 1'b0);
        check("idle_awready", {bus.AWREADY_M0, bus.AWREADY_M1}, 2'b00);
        tick();

        got = sb_q.pop_front();
        check("addr_id", bus.MasterID, got.id);
        check("addr_awaddr", bus.AWADDR, got.addr);
        check("addr_sel", bus.WriteAddressSel, got.sel);
        check("addr_awvalid", bus.AWVALID, 1'b1);
        check("addr_awready_g", awready_of(g), 1'b1);
        check("addr_awready_o", awready_of(!g), 1'b0);
        // Early W data must be stalled until the AW handshake completes.
        bus.WREADY = 1'b1;
        drive_m(g, 1'b1, 1'b1, v.beats == 1, 1'b0);
        #1;
        check("early_wready", {bus.WREADY_M0, bus.WREADY_M1, bus.WVALID}, 3'b000);
        tick();

        if (v.midreq) begin
            if (g) bus.AWVALID_M0 = 1'b1;
            else bus.AWVALID_M1 = 1'b1;
        end
        hs = 0;
        cyc = 0;
        while (hs < v.beats && cyc < 64) begin
            bus.WREADY = v.toggle ? cyc[0] : 1'b1;
            drive_m(g, 1'b0, 1'b1, hs == v.beats - 1, 1'b0);
            #1;
            check("data_sel", bus.WriteDataSel, got.sel);
            check("data_awready_o", awready_of(!g), 1'b0);
            check("data_wready_g", wready_of(g), bus.WREADY);
            check("data_wready_o", wready_of(!g), 1'b0);
            if (wready_of(g) && bus.WVALID) hs++;
            cyc++;
            tick();
        end
        check("beats", hs, v.beats);

        drive_m(g, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.WREADY = 1'b0;
        bus.BVALID = 1'b1;
        for (int i = 0; i < v.bwait; i++) begin
            #1;
            check("resp_wait_sel", bus.WriteRespSel, got.sel);
            check("resp_wait_id", bus.MasterID, got.id);
            check("resp_wait_b", {bvalid_of(g), bvalid_of(!g), bus.BREADY}, 3'b100);
            check("resp_wait_awready_o", awready_of(!g), 1'b0);
            tick();
        end
        drive_m(g, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("resp_sel", bus.WriteRespSel, got.sel);
        check("resp_b", {bvalid_of(g), bvalid_of(!g), bus.BREADY}, 3'b101);
        check("resp_awaddr", bus.AWADDR, got.addr);
        tick();
        bus.BVALID = 1'b0;
        drive_m(g, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("post_id", bus.MasterID, 4'hF);
        check("post_sels", {bus.WriteAddressSel, bus.WriteDataSel, bus.WriteRespSel}, 6'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        vecs[0] = '{1'b1, 1'b0, 32'h0001_0004, 32'h0, 1, 1'b0, 1'b0, 0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h2000_0010, 2, 1'b0, 1'b0, 1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 32'h1000_0000, 32'h2000_0000, 1, 1'b0, 1'b0, 0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h1000_0004, 32'h2000_0004, 1, 1'b0, 1'b0, 0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 32'h1000_0008, 32'h2000_0008, 1, 1'b0, 1'b0, 0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'h1000_000C, 32'h2000_000C, 1, 1'b0, 1'b0, 0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 32'h0, 32'h3000_0100, 4, 1'b1, 1'b1, 0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 32'h4000_0000, 32'h0, 1, 1'b0, 1'b0, 3, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 32'h4000_0040, 32'h0, 2, 1'b0, 1'b0, 0, 1'b0};

        // Reset held with random inputs: everything cleared.
        reset = 1'b0;
        zero_inputs();
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            random_inputs();
            #1;
            check_cleared("reset");
        end
        zero_inputs();
        #2;
        reset = 1'b1;
        tick();
        check_cleared("post_reset");

        foreach (vecs[i]) do_txn(vecs[i]);

        // Reset during DATA abandons the transaction and restores prio to M0.
        bus.AWVALID_M0 = 1'b1; bus.AWADDR_M0 = 32'h5000_0000; bus.AWREADY = 1'b1;
        tick();
        bus.WVALID_M0 = 1'b1;
        tick();
        bus.AWVALID_M0 = 1'b0; bus.WREADY = 1'b1; bus.BVALID = 1'b1; bus.BREADY_M0 = 1'b1;
        #1;
        check("mid_data_sel", bus.WriteDataSel, 2'b01);
        check("mid_data_wready", bus.WREADY_M0, 1'b1);
        reset = 1'b0;
        #1;
        check_cleared("mid_reset");
        zero_inputs();
        tick();
        check_cleared("mid_reset_held");
        reset = 1'b1;
        rv = '{1'b1, 1'b1, 32'h6000_0000, 32'h7000_0000, 1, 1'b0, 1'b0, 0, 1'b0};
        do_txn(rv);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
